// File: rtl/input_byte_feeder.sv
// input_byte_feeder: circular byte buffer turning fixed-width ingress beats into a sliding window consumed at a variable rate.
module input_byte_feeder #(
  parameter int NUM_BYTES_INPUT_WIDTH  = 8,
  parameter int NUM_BYTES_OUTPUT_WIDTH = 16,
  parameter int FIFO_DEPTH             = 64
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic [NUM_BYTES_INPUT_WIDTH*8-1:0]        dataIn,
  input  logic                                      dataInValid,
  input  logic                                      dataInLast,
  input  logic [$clog2(NUM_BYTES_INPUT_WIDTH):0]    dataInBytes,
  output logic                                      dataInReady,
  output logic [NUM_BYTES_OUTPUT_WIDTH*8-1:0]       dataOut,
  output logic [$clog2(NUM_BYTES_OUTPUT_WIDTH):0]   dataOutBytesValid,
  output logic                                      dataOutLast,
  input  logic [$clog2(NUM_BYTES_OUTPUT_WIDTH):0]   bytesConsumed,
  output logic                                      streamDone,
  output logic                                      overrunError
);
  localparam int NI = NUM_BYTES_INPUT_WIDTH;
  localparam int NO = NUM_BYTES_OUTPUT_WIDTH;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int IW = $clog2(NI) + 1;
  localparam int OW = $clog2(NO) + 1;

  typedef enum logic {STREAM, DRAIN} state_e;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CW-1:0] count_q, count_d;
  state_e        state_q;
  logic          done_q, overrun_q;
  logic          accept, last_acc;
  logic [IW-1:0] n_in, n;
  logic [OW-1:0] win, c;

  assign dataInReady       = state_q == STREAM && !reset && (CW'(FIFO_DEPTH) - count_q >= CW'(NI));
  assign accept            = dataInValid && dataInReady;
  assign last_acc          = accept && dataInLast;
  assign n_in              = !dataInLast ? IW'(NI) : (dataInBytes > IW'(NI) ? IW'(NI) : dataInBytes);
  assign n                 = accept ? n_in : '0;
  assign win               = count_q > CW'(NO) ? OW'(NO) : OW'(count_q);
  assign c                 = bytesConsumed > win ? win : bytesConsumed;
  assign count_d           = count_q + CW'(n) - CW'(c);
  assign dataOutBytesValid = reset ? '0 : win;
  assign dataOutLast       = !reset && state_q == DRAIN && count_q <= CW'(NO);
  assign streamDone        = done_q;
  assign overrunError      = overrun_q;

  always_comb begin
    dataOut = '0;
    for (int i = 0; i < NO; i++) dataOut[8*i+:8] = mem_q[rd_ptr_q + PW'(i)];
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NI; i++)
      if (accept && IW'(i) < n_in) mem_q[wr_ptr_q + PW'(i)] <= dataIn[8*i+:8];
  end

  // A stream ends either when DRAIN empties or when its last beat leaves nothing buffered.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      state_q   <= STREAM;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      rd_ptr_q  <= rd_ptr_q + PW'(c);
      wr_ptr_q  <= wr_ptr_q + PW'(n);
      count_q   <= count_d;
      done_q    <= count_d == '0 && (last_acc || state_q == DRAIN);
      overrun_q <= overrun_q || bytesConsumed > win;
      state_q   <= last_acc && count_d != '0 ? DRAIN : (state_q == DRAIN && count_d == '0 ? STREAM : state_q);
    end
  end
endmodule

// File: tb/tb_input_byte_feeder.sv
// tb_input_byte_feeder: directed and random stimulus checked against a byte-queue model of the feeder.
module tb_input_byte_feeder;
  logic         clk = 1'b0;
  logic         reset;
  logic [63:0]  dataIn;
  logic         dataInValid, dataInLast;
  logic [3:0]   dataInBytes;
  logic         dataInReady;
  logic [127:0] dataOut;
  logic [4:0]   dataOutBytesValid;
  logic         dataOutLast;
  logic [4:0]   bytesConsumed;
  logic         streamDone, overrunError;

  int checks = 0, failures = 0;

  logic [7:0] q[$];
  logic [7:0] nxt;
  bit drain, ovr, done_exp;

  input_byte_feeder dut (
    .clk(clk), .reset(reset), .dataIn(dataIn), .dataInValid(dataInValid),
    .dataInLast(dataInLast), .dataInBytes(dataInBytes), .dataInReady(dataInReady),
    .dataOut(dataOut), .dataOutBytesValid(dataOutBytesValid), .dataOutLast(dataOutLast),
    .bytesConsumed(bytesConsumed), .streamDone(streamDone), .overrunError(overrunError)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    q.delete();
    nxt = 8'h00;
    drain = 0;
    ovr = 0;
    done_exp = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    dataInValid = 1'b0;
    bytesConsumed = '0;
    @(negedge clk);
    chk("rst_ready", {31'd0, dataInReady}, 32'd0);
    chk("rst_bvalid", {27'd0, dataOutBytesValid}, 32'd0);
    chk("rst_last", {31'd0, dataOutLast}, 32'd0);
    chk("rst_done", {31'd0, streamDone}, 32'd0);
    chk("rst_overrun", {31'd0, overrunError}, 32'd0);
    reset = 1'b0;
    model_clear();
  endtask

  task automatic step(input bit v, input bit l, input int nb, input int bc);
    int bv, c, n;
    bit rdy;
    @(negedge clk);
    rdy = !drain && (64 - q.size() >= 8);
    bv = q.size() < 16 ? q.size() : 16;
    chk("ready", {31'd0, dataInReady}, {31'd0, rdy});
    chk("bvalid", {27'd0, dataOutBytesValid}, bv);
    chk("last", {31'd0, dataOutLast}, {31'd0, drain && q.size() <= 16});
    chk("done", {31'd0, streamDone}, {31'd0, done_exp});
    chk("overrun", {31'd0, overrunError}, {31'd0, ovr});
    for (int i = 0; i < bv; i++) chk($sformatf("win%0d", i), {24'd0, dataOut[8*i+:8]}, {24'd0, q[i]});
    dataInValid = v;
    dataInLast = l;
    dataInBytes = nb[3:0];
    bytesConsumed = bc[4:0];
    for (int i = 0; i < 8; i++) dataIn[8*i+:8] = nxt + 8'(i);
    @(posedge clk);
    c = bc > bv ? bv : bc;
    if (bc > bv) ovr = 1;
    repeat (c) void'(q.pop_front());
    done_exp = 0;
    if (v && rdy) begin
      n = l ? (nb > 8 ? 8 : nb) : 8;
      for (int i = 0; i < n; i++) q.push_back(nxt + 8'(i));
      nxt = nxt + 8'(n);
      if (l) begin
        if (q.size() == 0) done_exp = 1;
        else drain = 1;
      end
    end else if (drain && q.size() == 0) begin
      drain = 0;
      done_exp = 1;
    end
  endtask

  task automatic drain_all();
    while (q.size() > 0) step(0, 0, 0, q.size() > 16 ? 16 : q.size());
  endtask

  initial begin
    int bv, bc;
    reset = 1'b1;
    dataIn = '0;
    dataInValid = 1'b0;
    dataInLast = 1'b0;
    dataInBytes = '0;
    bytesConsumed = '0;
    model_clear();
    do_reset();
    repeat (4) step(1, 0, 0, 0);
    step(0, 0, 0, 5);
    step(0, 0, 0, 11);
    repeat (7) step(1, 0, 0, 0);
    step(0, 0, 0, 8);
    repeat (2) step(1, 0, 0, 0);
    drain_all();
    step(1, 1, 3, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 3);
    step(0, 0, 0, 0);
    step(1, 1, 2, 0);
    step(0, 0, 0, 4);
    repeat (2) step(0, 0, 0, 0);
    do_reset();
    step(1, 1, 0, 0);
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    step(1, 1, 2, 0);
    step(0, 0, 0, 0);
    do_reset();
    step(1, 0, 0, 0);
    step(1, 1, 13, 0);
    drain_all();
    repeat (4000) begin
      if ($urandom % 500 == 0) do_reset();
      bv = q.size() < 16 ? q.size() : 16;
      bc = ($urandom % 50 == 0) ? int'($urandom % 17) : int'($urandom_range(0, bv));
      step($urandom % 4 != 0, $urandom % 20 == 0, $urandom % 10, bc);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
